key_decoder: RTL and testbench
==============================

KEY_DECODER -- requirements
Module: key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65000, clk cycles without a ps2_clk falling edge before a partial frame is discarded (1 ms at 65 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop count on ps2_clk and ps2_data.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous, idle high.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous, idle high.
REQ-007 SHALL have port key_space  output  1  level, 1 while Space is held; feeds the jump controller.
REQ-008 SHALL have port key_left  output  1  level, 1 while Left Arrow is held; feeds the jump controller.
REQ-009 SHALL have port key_right  output  1  level, 1 while Right Arrow is held; feeds the jump controller.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse per rejected frame.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flops each and detect a ps2_clk falling edge as previous synced 1, current synced 0.
REQ-012 SHALL sample synced ps2_data on each falling edge into an 11-bit frame: start (0), 8 data bits LSB first, odd parity, stop (1); 4-bit bit counter 0..10.
REQ-013 SHALL emit a one-cycle byte strobe with the 8-bit code on the cycle after the 11th bit is sampled, if start=0, stop=1 and data+parity has an odd number of ones.
REQ-014 SHALL, on any start, stop or parity violation, drop the byte, pulse frame_err for one cycle, and return the bit counter to 0.
REQ-015 SHALL count clk cycles since the last falling edge while the bit counter is nonzero; at TIMEOUT_CYCLES, clear the bit counter without a strobe or frame_err.
REQ-016 SHALL decode bytes with FSM states IDLE, EXT, BRK, EXT_BRK; state changes occur only on a byte strobe.
REQ-017 IDLE: 0xE0 -> EXT; 0xF0 -> BRK; 0x29 -> key_space=1, stay IDLE; any other byte ignored, stay IDLE.
REQ-018 EXT: 0xF0 -> EXT_BRK; 0x6B -> key_left=1, go IDLE; 0x74 -> key_right=1, go IDLE; 0xE0 stay EXT; other -> IDLE, no output change.
REQ-019 BRK: 0x29 -> key_space=0; any byte -> IDLE.
REQ-020 EXT_BRK: 0x6B -> key_left=0; 0x74 -> key_right=0; any byte -> IDLE.
REQ-021 SHALL register key outputs, changing on the clk edge after the decoding byte strobe; total latency at most SYNC_STAGES+3 cycles from the ps2_clk falling edge of the stop bit.
REQ-022 SHALL treat repeated make codes (typematic) as idempotent; outputs stay 1 with no glitch.
REQ-023 SHALL allow key_left and key_right to be 1 simultaneously; arbitration belongs to the jump controller.
REQ-024 SHALL force the FSM to IDLE on a frame_err pulse, leaving key levels unchanged.

Reset
REQ-025 SHALL, on rst assertion and regardless of clk: key_space=key_left=key_right=0, frame_err=0, FSM=IDLE, bit counter=0, timeout counter=0, synchronizer flops=1.
REQ-026 SHALL discard a frame in progress when reset is asserted mid-frame; after release, the next frame SHALL be received correctly from its start bit.

Structure
REQ-027 SHALL place scan-code constants (SC_EXT=0xE0, SC_BRK=0xF0, SC_SPACE=0x29, SC_LEFT=0x6B, SC_RIGHT=0x74) and the decoder state enum in the shared jump_king_pkg.
REQ-028 SHALL implement synchronizers, framing, parity and timeout in sub-module ps2_rx (outputs: 8-bit code, byte strobe, frame_err); key_decoder instantiates it and holds the FSM.

Verification
REQ-029 Send 0x29 then F0 29 (PS/2 bit period 40 us) -> key_space rises within 5 clk after the first stop bit, falls after the 0x29 following F0; left and right stay 0.
REQ-030 Send E0 6B, E0 74, E0 F0 6B -> key_left=1, then both 1, then key_left=0 with key_right=1.
REQ-031 Send 0x29 with even parity -> frame_err pulses exactly 1 cycle; key_space stays 0; next valid 0x29 sets key_space=1.
REQ-032 Send 5 bits, then idle 1.5 ms, then full 0x29 frame -> no strobe or frame_err from the fragment; key_space=1.
REQ-033 Hold Space (0x29 repeated 10 times) -> key_space steady 1; send 0x1C (A) make/break -> no output change.
REQ-034 Assert rst for 3 cycles mid-frame while key_right=1 -> all outputs 0 immediately; next E0 74 sets key_right=1.

Source files
------------

// File: rtl/jump_king_pkg.sv
// Shared definitions for the jump king keyboard path: PS/2 scan codes,
// decoder state encoding and the frame validity check.
package jump_king_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } dec_state_t;

  // Frame layout: [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
  function automatic logic frame_ok(input logic [10:0] f);
    return ~f[0] & f[10] & (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: line synchronizers, 11-bit framing, parity
// check and a stall timeout that drops partial frames.
module ps2_rx
  import jump_king_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       byte_stb,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_cur;
  logic                   data_cur;
  logic                   fall;
  logic [3:0]             bit_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic [10:0]            shift_q;
  logic [10:0]            frame_next;

  assign clk_cur    = clk_sync[SYNC_STAGES-1];
  assign data_cur   = data_sync[SYNC_STAGES-1];
  assign fall       = clk_prev & ~clk_cur;
  assign frame_next = {data_cur, shift_q[10:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
      bit_cnt   <= 4'd0;
      tmo_cnt   <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clk_sync  <= (clk_sync << 1) | SYNC_STAGES'(ps2_clk);
      data_sync <= (data_sync << 1) | SYNC_STAGES'(ps2_data);
      clk_prev  <= clk_cur;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_ok(frame_next)) byte_stb  <= 1'b1;
          else                      frame_err <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        // A stalled partial frame is dropped silently.
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt <= 4'd0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // Frame data is qualified by byte_stb, so it carries no reset.
  always_ff @(posedge clk) begin
    if (fall) shift_q <= frame_next;
    if (fall && bit_cnt == 4'd10) code <= frame_next[8:1];
  end

endmodule

// File: rtl/key_decoder.sv
// Turns PS/2 set-2 scan codes into held-key levels for Space, Left and Right.
module key_decoder
  import jump_king_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic key_space,
  output logic key_left,
  output logic key_right,
  output logic frame_err
);

  logic [7:0] code;
  logic       byte_stb;
  dec_state_t state, state_n;
  logic       space_n, left_n, right_n;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .code     (code),
    .byte_stb (byte_stb),
    .frame_err(frame_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_space <= 1'b0;
      key_left  <= 1'b0;
      key_right <= 1'b0;
    end else begin
      state     <= state_n;
      key_space <= space_n;
      key_left  <= left_n;
      key_right <= right_n;
    end
  end

  always_comb begin
    state_n = state;
    space_n = key_space;
    left_n  = key_left;
    right_n = key_right;
    if (frame_err) begin
      // A corrupted byte may have been a prefix; resynchronize on the next one.
      state_n = IDLE;
    end else if (byte_stb) begin
      case (state)
        IDLE: begin
          if      (code == SC_EXT)   state_n = EXT;
          else if (code == SC_BRK)   state_n = BRK;
          else if (code == SC_SPACE) space_n = 1'b1;
        end
        EXT: begin
          state_n = IDLE;
          if      (code == SC_BRK)   state_n = EXT_BRK;
          else if (code == SC_EXT)   state_n = EXT;
          else if (code == SC_LEFT)  left_n  = 1'b1;
          else if (code == SC_RIGHT) right_n = 1'b1;
        end
        BRK: begin
          state_n = IDLE;
          if (code == SC_SPACE) space_n = 1'b0;
        end
        default: begin
          state_n = IDLE;
          if      (code == SC_LEFT)  left_n  = 1'b0;
          else if (code == SC_RIGHT) right_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_decoder.sv
// Bench for key_decoder: directed vector table, multi-cycle corner sequences
// and randomized scan-code traffic checked against a byte-sequence model.
module tb_key_decoder;
  import jump_king_pkg::*;

  localparam int HALF = 20;
  localparam int TMO  = 200;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic key_space, key_left, key_right, frame_err;

  key_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_space(key_space),
    .key_left (key_left),
    .key_right(key_right),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int err_long = 0;
  logic err_prev = 1'b0;
  bit hold_on = 1'b0;
  int space_drop = 0;

  always @(negedge clk) begin
    if (frame_err) begin
      if (err_prev) err_long <= err_long + 1;
      else          err_cnt  <= err_cnt + 1;
    end
    err_prev <= frame_err;
    if (hold_on && !key_space) space_drop <= space_drop + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1);
  end

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_keys(input string name, input bit sp, input bit lf, input bit rt);
    check_int({name, " key_space"}, int'(key_space), int'(sp));
    check_int({name, " key_left"},  int'(key_left),  int'(lf));
    check_int({name, " key_right"}, int'(key_right), int'(rt));
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One PS/2 bit: data set while ps2_clk is high, sampled on its fall.
  task automatic ps2_bit(input bit b, input bit measure, output int lat);
    lat = -1;
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clk);
      if (measure && lat < 0 && key_space) lat = i;
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit measure, output int lat);
    logic [10:0] bits;
    int l;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = (~^b) ^ bad_par;
    bits[10]  = ~bad_stop;
    lat = -1;
    for (int i = 0; i < nbits; i++) begin
      ps2_bit(bits[i], measure && (i == 10), l);
      if (i == 10) lat = l;
    end
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic send(input logic [7:0] b);
    int l;
    send_frame(b, 1'b0, 1'b0, 11, 1'b0, l);
  endtask

  // Reference model: keys held, plus the pending prefix bytes seen so far.
  logic [7:0] pend[$];
  bit m_sp, m_lf, m_rt;

  task automatic model_byte(input logic [7:0] b);
    if (pend.size() == 0) begin
      if (b == SC_EXT || b == SC_BRK) pend.push_back(b);
      else if (b == SC_SPACE) m_sp = 1'b1;
    end else if (pend.size() == 1 && pend[0] == SC_EXT) begin
      if (b == SC_BRK) pend.push_back(b);
      else if (b != SC_EXT) begin
        if (b == SC_LEFT)  m_lf = 1'b1;
        if (b == SC_RIGHT) m_rt = 1'b1;
        pend.delete();
      end
    end else if (pend.size() == 1) begin
      if (b == SC_SPACE) m_sp = 1'b0;
      pend.delete();
    end else begin
      if (b == SC_LEFT)  m_lf = 1'b0;
      if (b == SC_RIGHT) m_rt = 1'b0;
      pend.delete();
    end
  endtask

  typedef struct {
    logic [7:0] code;
    bit bad_par;
    bit bad_stop;
    bit exp_err;
    bit sp;
    bit lf;
    bit rt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat, e0;
    logic [7:0] pick[7];
    logic [7:0] b;
    bit bad;

    vecs.push_back('{SC_SPACE, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{SC_BRK,   0, 0, 0, 1, 0, 0});
    vecs.push_back('{SC_SPACE, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{SC_EXT,   0, 0, 0, 0, 0, 0});
    vecs.push_back('{SC_LEFT,  0, 0, 0, 0, 1, 0});
    vecs.push_back('{SC_EXT,   0, 0, 0, 0, 1, 0});
    vecs.push_back('{SC_RIGHT, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{SC_EXT,   0, 0, 0, 0, 1, 1});
    vecs.push_back('{SC_BRK,   0, 0, 0, 0, 1, 1});
    vecs.push_back('{SC_LEFT,  0, 0, 0, 0, 0, 1});
    vecs.push_back('{SC_SPACE, 1, 0, 1, 0, 0, 1});
    vecs.push_back('{SC_SPACE, 0, 0, 0, 1, 0, 1});
    vecs.push_back('{SC_EXT,   0, 0, 0, 1, 0, 1});
    vecs.push_back('{SC_BRK,   0, 0, 0, 1, 0, 1});
    vecs.push_back('{SC_RIGHT, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{SC_EXT,   0, 0, 0, 1, 0, 0});
    vecs.push_back('{SC_RIGHT, 0, 1, 1, 1, 0, 0});
    vecs.push_back('{SC_RIGHT, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{SC_EXT,   0, 0, 0, 1, 0, 0});
    vecs.push_back('{SC_LEFT,  1, 0, 1, 1, 0, 0});
    vecs.push_back('{SC_LEFT,  0, 0, 0, 1, 0, 0});
    vecs.push_back('{SC_BRK,   0, 0, 0, 1, 0, 0});
    vecs.push_back('{SC_SPACE, 0, 0, 0, 0, 0, 0});

    // Reset state
    wait_cyc(3);
    check_keys("reset", 1'b0, 1'b0, 1'b0);
    check_int("reset frame_err", int'(frame_err), 0);
    rst = 1'b0;
    wait_cyc(5);

    // First Space make also checks stop-bit-to-output latency.
    e0 = err_cnt;
    send_frame(SC_SPACE, 1'b0, 1'b0, 11, 1'b1, lat);
    check_int("space latency in range", int'(lat >= 1 && lat <= SYNC + 3), 1);
    check_keys("first space", 1'b1, 1'b0, 1'b0);
    send(SC_BRK);
    send(SC_SPACE);
    check_keys("space release", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      e0 = err_cnt;
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop, 11, 1'b0, lat);
      check_keys($sformatf("vec%0d", i), vecs[i].sp, vecs[i].lf, vecs[i].rt);
      check_int($sformatf("vec%0d frame_err pulses", i), err_cnt - e0, int'(vecs[i].exp_err));
    end
    check_int("frame_err pulse width", err_long, 0);

    // Typematic hold, then an unrelated key make/break.
    send(SC_SPACE);
    hold_on = 1'b1;
    for (int i = 0; i < 10; i++) send(SC_SPACE);
    send(8'h1C);
    send(SC_BRK);
    send(8'h1C);
    hold_on = 1'b0;
    check_int("space held without drop", space_drop, 0);
    check_keys("hold and A", 1'b1, 1'b0, 1'b0);
    send(SC_BRK);
    send(SC_SPACE);
    check_keys("hold release", 1'b0, 1'b0, 1'b0);

    // Fragment then stall past the timeout; the next full frame must decode.
    e0 = err_cnt;
    send_frame(SC_EXT, 1'b0, 1'b0, 5, 1'b0, lat);
    wait_cyc(TMO + TMO / 2);
    check_int("fragment frame_err", err_cnt - e0, 0);
    check_keys("fragment", 1'b0, 1'b0, 1'b0);
    send(SC_SPACE);
    check_int("after timeout frame_err", err_cnt - e0, 0);
    check_keys("after timeout", 1'b1, 1'b0, 1'b0);
    send(SC_BRK);
    send(SC_SPACE);

    // Reset mid-frame while Right is held.
    send(SC_EXT);
    send(SC_RIGHT);
    check_keys("right before reset", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1, 1'b0, lat);
    rst = 1'b1;
    #1;
    check_keys("async reset", 1'b0, 1'b0, 1'b0);
    check_int("async reset frame_err", int'(frame_err), 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    e0 = err_cnt;
    send(SC_EXT);
    send(SC_RIGHT);
    check_keys("after reset", 1'b0, 1'b0, 1'b1);
    check_int("after reset frame_err", err_cnt - e0, 0);

    // Randomized traffic against the model.
    m_sp = 1'b0; m_lf = 1'b0; m_rt = 1'b1;
    pend.delete();
    pick[0] = SC_EXT;  pick[1] = SC_BRK;   pick[2] = SC_SPACE;
    pick[3] = SC_LEFT; pick[4] = SC_RIGHT; pick[5] = 8'h1C;
    for (int i = 0; i < 30; i++) begin
      int k;
      k = $urandom_range(0, 6);
      b = (k == 6) ? 8'($urandom) : pick[k];
      bad = ($urandom_range(0, 7) == 0);
      e0 = err_cnt;
      send_frame(b, bad, 1'b0, 11, 1'b0, lat);
      if (bad) pend.delete();
      else     model_byte(b);
      check_keys($sformatf("rand%0d code %02h", i, b), m_sp, m_lf, m_rt);
      check_int($sformatf("rand%0d frame_err pulses", i), err_cnt - e0, int'(bad));
    end
    check_int("final frame_err pulse width", err_long, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
